// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning the HI/LO registers.
// Optional MIPS_MULDIV_EARLY_TERM_EN ends a multiply once the multiplier is exhausted.
module mips_cpu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_read,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic [CNT_W-1:0]   counter;
    logic               neg;
    logic               neg_r;
    logic               is_div;
    logic               div_zero;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        abs_a     = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        abs_b     = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        rem_sh    = {rem, quo[WIDTH-1]};
        rem_ge    = rem_sh >= {1'b0, divisor};
        // Result is below divisor whenever used, so the carry-out can be dropped.
        rem_sub   = rem_sh[WIDTH-1:0] - divisor;
    end

    assign stall = busy && (start || hilo_read);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            counter  <= '0;
            neg      <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (clk_enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            OP_MULT, OP_MULTU: begin
                                neg      <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                acc      <= '0;
                                mcand    <= {{WIDTH{1'b0}}, abs_a};
                                mplier   <= abs_b;
                                counter  <= '0;
                                is_div   <= 1'b0;
                                div_zero <= 1'b0;
                                busy     <= 1'b1;
                                state    <= RUN_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                neg     <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                neg_r   <= is_signed && rs_data[WIDTH-1];
                                divisor <= abs_b;
                                rem     <= '0;
                                counter <= '0;
                                is_div  <= 1'b1;
                                busy    <= 1'b1;
                                // Zero divisor parks the raw dividend in quo for FIX to copy into HI.
                                if (rt_data == '0) begin
                                    div_zero <= 1'b1;
                                    quo      <= rs_data;
                                    state    <= FIX;
                                end else begin
                                    div_zero <= 1'b0;
                                    quo      <= abs_a;
                                    state    <= RUN_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
`ifdef MIPS_MULDIV_EARLY_TERM_EN
                    if (counter == CNT_LAST || (mplier >> 1) == '0) state <= FIX;
`else
                    if (counter == CNT_LAST) state <= FIX;
`endif
                end
                RUN_DIV: begin
                    rem     <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    quo     <= {quo[WIDTH-2:0], rem_ge};
                    counter <= counter + 1'b1;
                    if (counter == CNT_LAST) state <= FIX;
                end
                FIX: begin
                    if (div_zero) begin
                        hi <= quo;
                        lo <= '1;
                    end else if (is_div) begin
                        lo <= neg ? -quo : quo;
                        hi <= neg_r ? -rem : rem;
                    end else begin
                        {hi, lo} <= neg ? -acc : acc;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Directed bench for mips_cpu_muldiv_unit: latency, results, handshake, reset and enable.
module tb_mips_cpu_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hilo_read;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mips_cpu_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hilo_read(hilo_read),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    localparam int LAT_M3X7 = 4;
    localparam int LAT_3X5  = 4;
    localparam int LAT_2X3  = 3;
`else
    localparam int LAT_M3X7 = 33;
    localparam int LAT_3X5  = 33;
    localparam int LAT_2X3  = 33;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int no_stall;
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd0;
        rs_data = '0; rt_data = '0; hilo_read = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;

        // MULT -3 * 7
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        check("mult_lat", n, LAT_M3X7);
        check("mult_done", done, 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        @(negedge clk);
        check("mult_done_pulse", done, 0);

        // MULTU max * max
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        check("multu_lat", n, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // MULTU 3 * 5
        issue(3'd2, 32'd3, 32'd5);
        wait_idle(n);
        check("multu35_lat", n, LAT_3X5);
        check("multu35_hi", hi, 0);
        check("multu35_lo", lo, 15);

        // DIV -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_lat", n, 33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100 / 0
        issue(3'd4, 32'd100, 32'd0);
        wait_idle(n);
        check("div0_lat", n, 1);
        check("div0_done", done, 1);
        check("div0_hi", hi, 100);
        check("div0_lo", lo, 32'hFFFF_FFFF);

        // DIV overflow 0x80000000 / -1
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 0);

        // DIVU 100 / 7 with hilo_read held and a second start while busy
        issue(3'd4, 32'd100, 32'd7);
        hilo_read = 1'b1;
        start = 1'b1; op = 3'd4; rs_data = 32'd50; rt_data = 32'd5;
        n = 0; no_stall = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (stall !== 1'b1) no_stall++;
            @(negedge clk);
        end
        start = 1'b0; op = 3'd0;
        check("rd_lat", n, 33);
        check("rd_stall_each_busy", no_stall, 0);
        check("rd_stall_drop", stall, 0);
        check("rd_done", done, 1);
        check("rd_lo", lo, 14);
        check("rd_hi", hi, 2);
        hilo_read = 1'b0;
        @(negedge clk);
        check("rd_second_ignored", busy, 0);

        // MTHI while idle
        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", busy, 0);
        check("mthi_done", done, 0);

        // MTLO while a MULTU is in flight
        issue(3'd2, 32'd2, 32'd3);
        start = 1'b1; op = 3'd6; rs_data = 32'hCAFE_BABE; rt_data = 32'd0;
        #1;
        check("mtlo_stall", stall, 1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("mtlo_mul_lat", n, LAT_2X3);
        check("mtlo_mul_lo", lo, 6);
        check("mtlo_mul_done", done, 1);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check("mtlo_lo", lo, 32'hCAFE_BABE);
        check("mtlo_hi", hi, 0);
        check("mtlo_busy", busy, 0);

        // Reset 10 cycles into a MULTU
        issue(3'd2, 32'd5, 32'h8000_0000);
        repeat (9) @(negedge clk);
        check("rstmid_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", busy, 0);
        check("rstmid_hi", hi, 0);
        check("rstmid_lo", lo, 0);
        check("rstmid_done", done, 0);
        @(negedge clk);
        check("rstmid_no_done", done, 0);

        // DIVU 1000 / 3 with clk_enable low for 5 cycles
        issue(3'd4, 32'd1000, 32'd3);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 5) clk_enable = 1'b0;
            if (n == 10) clk_enable = 1'b1;
            @(negedge clk);
        end
        check("en_lat", n, 38);
        check("en_lo", lo, 333);
        check("en_hi", hi, 1);
        check("en_done", done, 1);
        clk_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("en_done_hold", done, 1);
        clk_enable = 1'b1;
        @(negedge clk);
        check("en_done_clear", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_cpu_muldiv_unit.md
Name: mips_cpu_muldiv_unit

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Owns the architectural HI/LO registers.
- Replaces the combinational product/quotient/remainder logic in the CPU core with an iterative shift-add multiplier and a restoring divider.
- Provides a busy/done handshake and a stall output so the core holds the PC while a HI/LO access is blocked.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_enable  input  1  when low, all state holds.
- start  input  1  request valid this cycle.
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_data  input  WIDTH  operand a (dividend/multiplicand; MTHI/MTLO source).
- rt_data  input  WIDTH  operand b (divisor/multiplier).
- hilo_read  input  1  core is executing MFHI/MFLO this cycle.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse after HI/LO are updated by MULT/DIV.
- stall  output  1  combinational: busy && (start || hilo_read).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, counter=0, all internal operand registers 0. Reset overrides clk_enable. A reset mid-operation discards the operation with no HI/LO write.
- Accept condition: state IDLE, clk_enable=1, start=1. While busy, start is ignored and stall is raised; the core must hold start and operands until accepted.
- MTHI/MTLO: on the accept edge, hi (or lo) <= rs_data. No busy, no done.
- MULT/MULTU accept: latch |a| and |b| (MULTU: raw values) and the result-sign flag neg = a[31]^b[31] (signed only). acc=0, 64-bit mcand = zero-extended |a|, mplier = |b|, counter=0. Go to RUN_MUL.
- RUN_MUL, each enabled cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, counter++. After the iteration with counter=31, go to FIX.
- DIV/DIVU accept: latch |a|, |b|; neg_q = a[31]^b[31]; neg_r = a[31] (signed only). rem=0, quo = |a|. Go to RUN_DIV.
- RUN_DIV, each cycle: shift {rem,quo} left by 1; if rem >= |b|, then rem -= |b| and quo[0] = 1. After counter=31, go to FIX.
- Divide by zero (b=0) at accept: skip RUN. Go directly to FIX, which writes hi=rs_data (raw) and lo=32'hFFFFFFFF.
- FIX (1 cycle): mult: {hi,lo} <= neg ? -acc : acc. Div: lo <= neg_q ? -quo : quo; hi <= neg_r ? -rem : rem. Then return to IDLE; done=1 for the following cycle.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: result is the natural algorithm output, lo=0x80000000, hi=0.
- Latency (accept at edge 0): RUN occupies edges 1..32; FIX at edge 33. busy high for 33 cycles. New hi/lo and done visible after edge 33. Divide by zero: busy for 1 cycle, FIX at edge 1.
- Back-to-back: a new start may be accepted in the cycle done is high.
- clk_enable low: state, counter, hi, lo hold. done holds its value (it is not re-pulsed). stall remains combinational.

Optional Feature:
- Macro: MIPS_MULDIV_EARLY_TERM_EN.
- Defined: in RUN_MUL, when mplier is 0 after an iteration, go to FIX immediately. Multiply busy time = (index of the highest set bit of |b|) + 2 cycles. For b=0: 1 RUN cycle + FIX, i.e. 2 cycles. Divide timing is unchanged.
- Undefined: always 32 RUN iterations.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy exactly 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With EARLY_TERM_EN: MULTU 3*5 -> busy 4 cycles, lo=15, hi=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=0 -> busy 1 cycle, hi=100, lo=0xFFFFFFFF.
- Start DIVU 100/7, then hold hilo_read=1 -> stall=1 for every busy cycle, drops with busy. lo=14, hi=2 readable the cycle done is high. A second start during busy is ignored.
- MTHI rs=0x12345678 while idle -> hi updates next edge, busy stays 0, no done. MTLO issued while a MULT is busy -> stall=1, accepted after completion, overwriting lo.
- Assert reset at cycle 10 of a MULT -> next cycle busy=0, hi=lo=0, no done pulse. clk_enable low for 5 cycles mid-DIV -> latency extends by exactly 5 cycles, same result.
